// File: rtl/btb_pkg.sv
// Shared types, opcode constant and saturating-counter helpers for the BTB.
// Entry fields are sized for the widest legal configuration; narrower instances zero-extend.
package btb_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam int TAG_MAX_W = 30;
    localparam int CNT_MAX_W = 8;

    typedef logic [CNT_MAX_W-1:0] ctr_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        ctr_t                 ctr;
    } btb_entry_t;

    function automatic ctr_t ctr_max(input int unsigned cnt_w);
        return ctr_t'((1 << cnt_w) - 1);
    endfunction

    function automatic ctr_t sat_inc(input ctr_t ctr, input int unsigned cnt_w);
        return (ctr >= ctr_max(cnt_w)) ? ctr : ctr + ctr_t'(1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t ctr);
        return (ctr == '0) ? ctr : ctr - ctr_t'(1);
    endfunction

    function automatic ctr_t weak_taken(input int unsigned cnt_w);
        return ctr_t'(1) << (cnt_w - 1);
    endfunction

endpackage

// File: rtl/btb_way.sv
// One way of the BTB: SETS entries, a fetch-side compare port, an EX-side
// compare port and a single write port addressed by the EX set index.
module btb_way
    import btb_pkg::*;
#(
    parameter int INDEX_LEN = 6,
    parameter int CNT_W     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inv_i,
    input  logic [INDEX_LEN-1:0]   if_idx_i,
    input  logic [29-INDEX_LEN:0]  if_tag_i,
    output logic                   if_hit_o,
    output logic                   if_taken_o,
    output logic [31:0]            if_target_o,
    input  logic [INDEX_LEN-1:0]   ex_idx_i,
    input  logic [29-INDEX_LEN:0]  ex_tag_i,
    output logic                   ex_valid_o,
    output logic                   ex_hit_o,
    output logic [31:0]            ex_target_o,
    output logic [CNT_W-1:0]       ex_ctr_o,
    input  logic                   we_i,
    input  logic [29-INDEX_LEN:0]  wr_tag_i,
    input  logic [31:0]            wr_target_i,
    input  logic [CNT_W-1:0]       wr_ctr_i
);

    localparam int SETS = 1 << INDEX_LEN;

    btb_entry_t mem_q [SETS];
    btb_entry_t wr_entry;

    assign if_hit_o    = mem_q[if_idx_i].valid && (mem_q[if_idx_i].tag == TAG_MAX_W'(if_tag_i));
    assign if_taken_o  = mem_q[if_idx_i].ctr[CNT_W-1];
    assign if_target_o = mem_q[if_idx_i].target;

    assign ex_valid_o  = mem_q[ex_idx_i].valid;
    assign ex_hit_o    = mem_q[ex_idx_i].valid && (mem_q[ex_idx_i].tag == TAG_MAX_W'(ex_tag_i));
    assign ex_target_o = mem_q[ex_idx_i].target;
    assign ex_ctr_o    = CNT_W'(mem_q[ex_idx_i].ctr);

    always_comb begin
        wr_entry        = '0;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = TAG_MAX_W'(wr_tag_i);
        wr_entry.target = wr_target_i;
        wr_entry.ctr    = ctr_t'(wr_ctr_i);
    end

    // Invalidation only drops valid bits; stale tag/target/ctr become unreachable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) mem_q[s] <= '0;
        end else if (inv_i) begin
            for (int s = 0; s < SETS; s++) mem_q[s].valid <= 1'b0;
        end else if (we_i) begin
            mem_q[ex_idx_i] <= wr_entry;
        end
    end

endmodule

// File: rtl/btb_assoc.sv
// N-way set-associative BTB with saturating-counter direction prediction,
// LRU replacement, bulk invalidation and saturating branch/mispredict statistics.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int INDEX_LEN = 6,
    parameter int WAYS      = 2,
    parameter int CNT_W     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_if,
    output logic [31:0] pred_pc_if,
    output logic        pred_taken_if,
    output logic        pred_hit_if,
    input  logic        ex_valid,
    input  logic        ex_is_br,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_taken,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_pc,
    output logic        ex_mispredict,
    input  logic        inv_all,
    output logic [31:0] br_cnt,
    output logic [31:0] mis_cnt
);

    localparam int SETS  = 1 << INDEX_LEN;
    localparam int TAG_W = 30 - INDEX_LEN;

    logic [INDEX_LEN-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0]     if_tag, ex_tag;

    logic [WAYS-1:0]  if_hit_w, if_taken_w, ex_vld_w, ex_hit_w, we_w;
    logic [31:0]      if_tgt_w [WAYS];
    logic [31:0]      ex_tgt_w [WAYS];
    logic [CNT_W-1:0] ex_ctr_w [WAYS];

    logic             if_hit, if_taken;
    logic [31:0]      if_tgt;
    logic             ex_hit, hit_way, victim_way, wr_way, lru_way;
    logic [31:0]      ex_old_tgt, wr_target;
    logic [CNT_W-1:0] ex_ctr, wr_ctr;
    logic             upd, br_seen, wr_en;
    logic [31:0]      br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
    logic             unused_pc_bits;

    assign if_idx = pc_if[INDEX_LEN+1:2];
    assign if_tag = pc_if[31:INDEX_LEN+2];
    assign ex_idx = ex_pc[INDEX_LEN+1:2];
    assign ex_tag = ex_pc[31:INDEX_LEN+2];
    assign unused_pc_bits = ^{pc_if[1:0], ex_pc[1:0]};

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            btb_way #(
                .INDEX_LEN (INDEX_LEN),
                .CNT_W     (CNT_W)
            ) u_way (
                .clk         (clk),
                .rst_n       (rst_n),
                .inv_i       (inv_all),
                .if_idx_i    (if_idx),
                .if_tag_i    (if_tag),
                .if_hit_o    (if_hit_w[gi]),
                .if_taken_o  (if_taken_w[gi]),
                .if_target_o (if_tgt_w[gi]),
                .ex_idx_i    (ex_idx),
                .ex_tag_i    (ex_tag),
                .ex_valid_o  (ex_vld_w[gi]),
                .ex_hit_o    (ex_hit_w[gi]),
                .ex_target_o (ex_tgt_w[gi]),
                .ex_ctr_o    (ex_ctr_w[gi]),
                .we_i        (we_w[gi]),
                .wr_tag_i    (ex_tag),
                .wr_target_i (wr_target),
                .wr_ctr_i    (wr_ctr)
            );
            assign we_w[gi] = wr_en && (wr_way == 1'(gi));
        end
    endgenerate

    // Tags are unique within a set, so at most one way can hit.
    always_comb begin
        if_hit   = 1'b0;
        if_taken = 1'b0;
        if_tgt   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (if_hit_w[w]) begin
                if_hit   = 1'b1;
                if_taken = if_taken_w[w];
                if_tgt   = if_tgt_w[w];
            end
        end
    end

    assign pred_hit_if   = if_hit;
    assign pred_taken_if = if_hit & if_taken;
    assign pred_pc_if    = pred_taken_if ? if_tgt : pc_if + 32'd4;

    always_comb begin
        ex_hit     = 1'b0;
        hit_way    = 1'b0;
        ex_ctr     = '0;
        ex_old_tgt = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (ex_hit_w[w]) begin
                ex_hit     = 1'b1;
                hit_way    = 1'(w);
                ex_ctr     = ex_ctr_w[w];
                ex_old_tgt = ex_tgt_w[w];
            end
        end
    end

    generate
        if (WAYS > 1) begin : g_lru
            // lru_q[set] names the way to evict next.
            logic [SETS-1:0] lru_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)       lru_q         <= '0;
                else if (inv_all) lru_q         <= '0;
                else if (wr_en)   lru_q[ex_idx] <= ~wr_way;
            end
            assign lru_way    = lru_q[ex_idx];
            assign victim_way = !ex_vld_w[0]      ? 1'b0 :
                                !ex_vld_w[WAYS-1] ? 1'b1 : lru_way;
        end else begin : g_no_lru
            assign lru_way    = 1'b0;
            assign victim_way = lru_way;
        end
    endgenerate

    assign br_seen   = ex_valid & ex_is_br;
    assign upd       = br_seen & ~inv_all;
    assign wr_en     = upd & (ex_hit | ex_taken);
    assign wr_way    = ex_hit ? hit_way : victim_way;
    assign wr_target = (ex_hit && !ex_taken) ? ex_old_tgt : ex_target;

    always_comb begin
        wr_ctr = CNT_W'(weak_taken(CNT_W));
        if (ex_hit) begin
            if (ex_taken) wr_ctr = CNT_W'(sat_inc(ctr_t'(ex_ctr), CNT_W));
            else          wr_ctr = CNT_W'(sat_dec(ctr_t'(ex_ctr)));
        end
    end

    assign ex_mispredict = br_seen & ((ex_taken != ex_pred_taken) |
                                      (ex_taken & (ex_pred_pc != ex_target)));

    assign br_cnt_d  = (br_seen && br_cnt_q != '1)        ? br_cnt_q + 32'd1  : br_cnt_q;
    assign mis_cnt_d = (ex_mispredict && mis_cnt_q != '1) ? mis_cnt_q + 32'd1 : mis_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign br_cnt  = br_cnt_q;
    assign mis_cnt = mis_cnt_q;

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc: a recency-ordered per-set model checked every
// negedge, plus hand-computed literal expectations along the directed sequence.
module tb_btb_assoc;
    import btb_pkg::*;

    localparam int INDEX_LEN = 6;
    localparam int WAYS      = 2;
    localparam int CNT_W     = 2;
    localparam int SETS      = 64;
    localparam int CMAX      = (1 << CNT_W) - 1;
    localparam int WEAK      = 1 << (CNT_W - 1);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_if = 32'h100;
    logic [31:0] pred_pc_if;
    logic        pred_taken_if, pred_hit_if;
    logic        ex_valid = 1'b0, ex_is_br = 1'b0, ex_taken = 1'b0, ex_pred_taken = 1'b0;
    logic [31:0] ex_pc = '0, ex_target = '0, ex_pred_pc = '0;
    logic        ex_mispredict;
    logic        inv_all = 1'b0;
    logic [31:0] br_cnt, mis_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    btb_assoc #(.INDEX_LEN(INDEX_LEN), .WAYS(WAYS), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_if         (pc_if),
        .pred_pc_if    (pred_pc_if),
        .pred_taken_if (pred_taken_if),
        .pred_hit_if   (pred_hit_if),
        .ex_valid      (ex_valid),
        .ex_is_br      (ex_is_br),
        .ex_pc         (ex_pc),
        .ex_target     (ex_target),
        .ex_taken      (ex_taken),
        .ex_pred_taken (ex_pred_taken),
        .ex_pred_pc    (ex_pred_pc),
        .ex_mispredict (ex_mispredict),
        .inv_all       (inv_all),
        .br_cnt        (br_cnt),
        .mis_cnt       (mis_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each set is a list of at most WAYS entries, index 0 most recent.
    int          m_n   [SETS];
    int          m_tag [SETS][WAYS];
    logic [31:0] m_tgt [SETS][WAYS];
    int          m_ctr [SETS][WAYS];
    longint      br_m, mis_m;

    function automatic int set_of(input logic [31:0] pc);
        return int'((pc >> 2) % SETS);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'(pc >> (INDEX_LEN + 2));
    endfunction

    function automatic int find(input int s, input int t);
        for (int k = 0; k < m_n[s]; k++) if (m_tag[s][k] == t) return k;
        return -1;
    endfunction

    function automatic logic exp_mis();
        return ex_valid && ex_is_br &&
               ((ex_taken != ex_pred_taken) || (ex_taken && ex_pred_pc != ex_target));
    endfunction

    task automatic m_promote(input int s, input int p);
        int t; logic [31:0] g; int c;
        t = m_tag[s][p]; g = m_tgt[s][p]; c = m_ctr[s][p];
        for (int k = p; k > 0; k--) begin
            m_tag[s][k] = m_tag[s][k-1]; m_tgt[s][k] = m_tgt[s][k-1]; m_ctr[s][k] = m_ctr[s][k-1];
        end
        m_tag[s][0] = t; m_tgt[s][0] = g; m_ctr[s][0] = c;
    endtask

    task automatic m_insert(input int s, input int t, input logic [31:0] g);
        for (int k = WAYS - 1; k > 0; k--) begin
            m_tag[s][k] = m_tag[s][k-1]; m_tgt[s][k] = m_tgt[s][k-1]; m_ctr[s][k] = m_ctr[s][k-1];
        end
        m_tag[s][0] = t; m_tgt[s][0] = g; m_ctr[s][0] = WEAK;
        if (m_n[s] < WAYS) m_n[s]++;
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        int s, t, p;
        if (!rst_n) begin
            br_m = 0; mis_m = 0;
            for (int i = 0; i < SETS; i++) m_n[i] = 0;
        end else begin
            if (ex_valid && ex_is_br && br_m < 64'hFFFF_FFFF) br_m++;
            if (exp_mis() && mis_m < 64'hFFFF_FFFF) mis_m++;
            if (inv_all) begin
                for (int i = 0; i < SETS; i++) m_n[i] = 0;
            end else if (ex_valid && ex_is_br) begin
                s = set_of(ex_pc); t = tag_of(ex_pc); p = find(s, t);
                if (p >= 0) begin
                    if (ex_taken) begin
                        m_ctr[s][p] = (m_ctr[s][p] < CMAX) ? m_ctr[s][p] + 1 : CMAX;
                        m_tgt[s][p] = ex_target;
                    end else begin
                        m_ctr[s][p] = (m_ctr[s][p] > 0) ? m_ctr[s][p] - 1 : 0;
                    end
                    m_promote(s, p);
                end else if (ex_taken) begin
                    m_insert(s, t, ex_target);
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        int s, p;
        logic eh, et;
        logic [31:0] epc;
        s   = set_of(pc_if);
        p   = find(s, tag_of(pc_if));
        eh  = (p >= 0);
        et  = eh && (m_ctr[s][p] >= WEAK);
        epc = et ? m_tgt[s][p] : pc_if + 32'd4;
        chk("mdl_hit",     {31'd0, pred_hit_if},   {31'd0, eh});
        chk("mdl_taken",   {31'd0, pred_taken_if}, {31'd0, et});
        chk("mdl_pred_pc", pred_pc_if, epc);
        chk("mdl_mispred", {31'd0, ex_mispredict}, {31'd0, exp_mis()});
        chk("mdl_br_cnt",  br_cnt,  br_m[31:0]);
        chk("mdl_mis_cnt", mis_cnt, mis_m[31:0]);
    end

    task automatic drive(input logic [31:0] pcif, input logic v, input logic [6:0] opc,
                         input logic [31:0] epc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ppc, input logic inv);
        #1;
        pc_if = pcif; ex_valid = v; ex_is_br = (opc == OPC_BRANCH); ex_pc = epc;
        ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_pc = ppc; inv_all = inv;
        @(negedge clk);
    endtask

    task automatic br(input logic [31:0] pcif, input logic [31:0] epc, input logic tk,
                      input logic [31:0] tgt, input logic ptk, input logic [31:0] ppc);
        drive(pcif, 1'b1, OPC_BRANCH, epc, tk, tgt, ptk, ppc, 1'b0);
    endtask

    task automatic look(input logic [31:0] pcif);
        drive(pcif, 1'b0, OPC_BRANCH, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_hit",  {31'd0, pred_hit_if}, 32'd0);
        chk("rst_pc",   pred_pc_if, 32'h104);
        #1 rst_n = 1'b1;
        look(32'h100);
        chk("init_hit",   {31'd0, pred_hit_if},   32'd0);
        chk("init_taken", {31'd0, pred_taken_if}, 32'd0);
        chk("init_pc",    pred_pc_if, 32'h104);
        chk("init_cnts",  br_cnt | mis_cnt, 32'd0);

        br(32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        chk("alloc_mis",   {31'd0, ex_mispredict}, 32'd1);
        chk("alloc_miscnt", mis_cnt, 32'd1);
        chk("alloc_taken", {31'd0, pred_taken_if}, 32'd1);
        chk("alloc_pc",    pred_pc_if, 32'h80);

        br(32'h100, 32'h100, 1'b0, 32'h104, 1'b1, 32'h80);
        br(32'h100, 32'h100, 1'b0, 32'h104, 1'b0, 32'h104);
        br(32'h100, 32'h100, 1'b0, 32'h104, 1'b0, 32'h104);
        chk("sat0_hit",   {31'd0, pred_hit_if},   32'd1);
        chk("sat0_taken", {31'd0, pred_taken_if}, 32'd0);
        chk("sat0_pc",    pred_pc_if, 32'h104);
        br(32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        chk("ctr1_taken", {31'd0, pred_taken_if}, 32'd0);
        br(32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        chk("ctr2_taken", {31'd0, pred_taken_if}, 32'd1);
        chk("ctr2_pc",    pred_pc_if, 32'h80);
        chk("sat_brcnt",  br_cnt,  32'd6);
        chk("sat_miscnt", mis_cnt, 32'd4);

        br(32'h200, 32'h200, 1'b1, 32'h280, 1'b0, 32'h204);
        chk("w1_pc", pred_pc_if, 32'h280);
        br(32'h100, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        chk("hit_nomis", {31'd0, ex_mispredict}, 32'd0);
        br(32'h300, 32'h300, 1'b1, 32'h380, 1'b0, 32'h304);
        look(32'h200);
        chk("evict_200", {31'd0, pred_hit_if}, 32'd0);
        look(32'h100);
        chk("keep_100", {31'd0, pred_hit_if}, 32'd1);
        look(32'h300);
        chk("keep_300", pred_pc_if, 32'h380);

        br(32'h100, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
        chk("tgt_mis",    {31'd0, ex_mispredict}, 32'd1);
        chk("tgt_miscnt", mis_cnt, 32'd7);
        chk("tgt_pc",     pred_pc_if, 32'h90);

        drive(32'h100, 1'b1, 7'b0110011, 32'h500, 1'b1, 32'h600, 1'b0, 32'h504, 1'b0);
        chk("nonbr_mis", {31'd0, ex_mispredict}, 32'd0);
        chk("nonbr_br",  br_cnt, 32'd10);

        drive(32'h100, 1'b1, OPC_BRANCH, 32'h400, 1'b1, 32'h440, 1'b0, 32'h404, 1'b1);
        chk("inv_hit100", {31'd0, pred_hit_if}, 32'd0);
        chk("inv_brcnt",  br_cnt, 32'd11);
        look(32'h400);
        chk("inv_hit400", {31'd0, pred_hit_if}, 32'd0);

        br(32'h200, 32'h200, 1'b1, 32'h240, 1'b0, 32'h204);
        chk("realloc_pc", pred_pc_if, 32'h240);

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_hit",  {31'd0, pred_hit_if}, 32'd0);
        chk("arst_pc",   pred_pc_if, 32'h204);
        chk("arst_br",   br_cnt,  32'd0);
        chk("arst_mis",  mis_cnt, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        look(32'h200);
        chk("post_rst_hit", {31'd0, pred_hit_if}, 32'd0);
        br(32'h200, 32'h200, 1'b1, 32'h2c0, 1'b0, 32'h204);
        chk("post_rst_pc", pred_pc_if, 32'h2c0);
        look(32'h200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
Parametrised N-way set-associative branch target buffer with per-entry saturating-counter direction prediction, for the IF/EX pipeline.
- IF stage: combinational lookup returns a predicted next PC.
- EX stage: resolved conditional branches train the table, mispredictions are flagged, and 32-bit branch and mispredict statistics are kept.
- Improves on a 1-bit direct-mapped BTB with word-aligned indexing, valid bits, hysteresis, LRU replacement and bulk invalidation.

Parameters:
INDEX_LEN, 6, set index bits taken from PC[INDEX_LEN+1:2]; SETS = 2**INDEX_LEN
WAYS, 2, associativity; legal values 1 or 2
CNT_W, 2, saturating counter width; predict taken when counter MSB = 1

Ports:
clk  in  1  clock
rst_n  in  1  reset
pc_if  in  32  IF fetch PC
pred_pc_if  out  32  predicted next PC
pred_taken_if  out  1  prediction is taken
pred_hit_if  out  1  tag hit in some way
ex_valid  in  1  EX slot holds a valid instruction
ex_is_br  in  1  EX instruction is a conditional branch (opcode 1100011)
ex_pc  in  32  PC of the EX branch
ex_target  in  32  resolved branch target
ex_taken  in  1  resolved direction
ex_pred_taken  in  1  pred_taken_if carried down with the instruction
ex_pred_pc  in  32  pred_pc_if carried down with the instruction
ex_mispredict  out  1  prediction was wrong
inv_all  in  1  synchronous invalidate of all entries
br_cnt  out  32  count of resolved branches
mis_cnt  out  32  count of mispredicts

Behaviour:
- Reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low. While reset is asserted, all valid bits, counters, LRU bits, br_cnt and mis_cnt are 0. Targets and tags are don't-care.
- Outputs while in reset: pred_hit_if=0, pred_taken_if=0, pred_pc_if=pc_if+4, ex_mispredict follows its combinational equation.
- Address split: idx = pc[INDEX_LEN+1:2]; tag = pc[31:INDEX_LEN+2]. pc[1:0] is ignored.
- Lookup is combinational with zero latency:
  - hit = any way with valid and tag match.
  - pred_taken_if = hit & ctr[CNT_W-1].
  - pred_pc_if = target of the hit way if pred_taken_if, else pc_if+4 (mod 2^32).
  - Two ways never hold the same tag in one set, because allocation happens only on a miss.
- Update trigger: upd = ex_valid & ex_is_br & ~inv_all, applied at posedge clk.
  - Hit, taken: ctr = min(ctr+1, 2^CNT_W-1); target <= ex_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Hit, either direction: LRU bit of the set points to the other way.
  - Miss, taken: allocate the lowest-numbered invalid way, else the LRU way. Write valid=1, tag, target, ctr=2^(CNT_W-1) (weakly taken), then update LRU.
  - Miss, not taken: no allocation, no state change.
- WAYS=1: no LRU storage; allocation always goes to way 0.
- Same-cycle read/write to one set: lookup returns the pre-update contents (no bypass). The new contents are visible on the next cycle.
- ex_mispredict = ex_valid & ex_is_br & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_pc != ex_target)). Combinational.
- Statistics:
  - br_cnt increments on ex_valid & ex_is_br; mis_cnt increments on ex_mispredict.
  - Both saturate at 32'hFFFF_FFFF.
  - Both count regardless of inv_all.
- inv_all: clears every valid bit and LRU bit at posedge. It has priority over a simultaneous update, which is dropped; counters stay stale but unreachable.
- Non-branch EX instructions and ex_valid=0: no table or statistics change.

Decomposition:
- Package btb_pkg holds:
  - OPC_BRANCH = 7'b1100011
  - functions sat_inc/sat_dec(ctr) parametrised by CNT_W
  - function weak_taken()
  - typedef btb_entry_t {valid, tag, target, ctr}
- One sub-module, btb_way: one way's SETS-deep entry array, with a combinational read/compare port (hit, target, ctr) and a single write port. btb_assoc instantiates WAYS copies and owns LRU, allocation, statistics and mispredict logic.

Test Plan (INDEX_LEN=6, WAYS=2, CNT_W=2):
1. Reset released, pc_if=0x100 -> pred_hit_if=0, pred_taken_if=0, pred_pc_if=0x104; br_cnt=mis_cnt=0.
2. EX branch pc=0x100 taken to 0x80 (pred_taken=0) -> ex_mispredict=1, mis_cnt=1. Next cycle pc_if=0x100 -> hit=1, taken=1, pred_pc=0x80 (ctr=2).
3. Counter saturation:
   - Three not-taken updates on 0x100 -> ctr 1, 0, 0; pred_taken_if=0, pred_pc=0x104, hit=1.
   - Then two taken -> ctr 1, then 2; pred_taken_if=1.
4. LRU replacement:
   - Allocate 0x100, then 0x200 (both set 0), then hit-update 0x100.
   - Allocate 0x300 -> 0x200 is evicted. Lookup 0x200 -> hit=0; lookups 0x100 and 0x300 -> hit=1.
5. Target mispredict: ex_pred_taken=1, ex_pred_pc=0x80, ex_taken=1, ex_target=0x90 -> ex_mispredict=1, mis_cnt+1. Next lookup of 0x100 -> pred_pc=0x90.
6. inv_all asserted together with a taken EX update of 0x400 -> next cycle every lookup misses (0x100 and 0x400 hit=0) and br_cnt still incremented. Also assert rst_n=0 mid-stream, asynchronously, off a clock edge -> outputs and counters drop to reset values immediately.
